// File: rtl/ms_mul_div_arb_if.sv
// rtl/ms_mul_div_arb_if.sv - MulDiv port bundle shared by both requester links and the unit link.
// master issues operations and receives results; slave accepts operations and returns results.
interface ms_mul_div_arb_if;
    logic [31:0] DataS;
    logic [31:0] DataD;
    logic [1:0]  Start;
    logic [31:0] DataH;
    logic [31:0] DataR;
    logic        WrEn;
    logic        Busy;

    modport master (
        output DataS,
        output DataD,
        output Start,
        input  DataH,
        input  DataR,
        input  WrEn
    );

    modport slave (
        input  DataS,
        input  DataD,
        input  Start,
        output DataH,
        output DataR,
        output WrEn,
        output Busy
    );
endinterface

// File: rtl/ms_mul_div_arb.sv
// rtl/ms_mul_div_arb.sv - Int/FPU arbiter and sequencer for the shared iterative MulDiv unit.
// Optional BUSY-state abort after CTimeout cycles is enabled by defining MS_MULDIV_ARB_TIMEOUT_EN.
module ms_mul_div_arb
`ifdef MS_MULDIV_ARB_TIMEOUT_EN
#(
    parameter int unsigned CTimeout = 64
)
`endif
(
    input  logic             AClkH,
    input  logic             AResetHN,
    input  logic             AClkHEn,
    ms_mul_div_arb_if.slave  AInt,
    ms_mul_div_arb_if.slave  AFpu,
    ms_mul_div_arb_if.master AMulDiv,
    output logic             AErr
);

    typedef enum logic {
        StIdle,
        StBusy
    } state_t;

    state_t      state;
    logic [1:0]  pend;
    logic [1:0]  oper [2];
    logic [31:0] slotS [2];
    logic [31:0] slotD [2];
    logic        owner;
    logic        lastFpu;

    logic [1:0]  reqStart [2];
    logic [31:0] reqS [2];
    logic [31:0] reqD [2];
    logic [1:0]  busyVec;
    logic        issue;
    logic        grant;
    logic        done;
    logic        timeoutHit;

`ifdef MS_MULDIV_ARB_TIMEOUT_EN
    logic [15:0] toCnt;

    // Gated by the clock enable so a stalled abort cycle cannot repeat its strobe.
    assign timeoutHit = (state == StBusy) && !AMulDiv.WrEn && AClkHEn
                        && (toCnt == 16'(CTimeout - 1));

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            toCnt <= '0;
        end else if (AClkHEn) begin
            if (state == StIdle) begin
                toCnt <= '0;
            end else begin
                toCnt <= toCnt + 16'd1;
            end
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    always_comb begin
        reqStart[0] = AInt.Start;
        reqStart[1] = AFpu.Start;
        reqS[0]     = AInt.DataS;
        reqS[1]     = AFpu.DataS;
        reqD[0]     = AInt.DataD;
        reqD[1]     = AFpu.DataD;
        busyVec[0]  = pend[0] | ((state == StBusy) & ~owner);
        busyVec[1]  = pend[1] | ((state == StBusy) & owner);
        issue       = (state == StIdle) && (pend != 2'b00);
        // Fpu wins only when alone or when Int held the previous grant.
        grant       = pend[1] & (~pend[0] | ~lastFpu);
        done        = (state == StBusy) && (AMulDiv.WrEn || timeoutHit);
    end

    assign AMulDiv.Start = issue ? oper[grant]  : 2'b00;
    assign AMulDiv.DataS = issue ? slotS[grant] : 32'd0;
    assign AMulDiv.DataD = issue ? slotD[grant] : 32'd0;

    assign AInt.WrEn  = done & ~owner;
    assign AFpu.WrEn  = done & owner;
    assign AInt.Busy  = busyVec[0];
    assign AFpu.Busy  = busyVec[1];
    assign AInt.DataH = AMulDiv.DataH;
    assign AFpu.DataH = AMulDiv.DataH;
    assign AInt.DataR = (timeoutHit && !owner) ? 32'hFFFF_FFFF : AMulDiv.DataR;
    assign AFpu.DataR = (timeoutHit && owner)  ? 32'hFFFF_FFFF : AMulDiv.DataR;
    assign AErr       = timeoutHit;

    always_ff @(posedge AClkH) begin
        if (!AResetHN) begin
            state   <= StIdle;
            pend    <= 2'b00;
            owner   <= 1'b0;
            lastFpu <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                oper[i]  <= 2'b00;
                slotS[i] <= '0;
                slotD[i] <= '0;
            end
        end else if (AClkHEn) begin
            // A start from a busy requester is dropped; 2'b11 collapses to div.
            for (int i = 0; i < 2; i++) begin
                if ((reqStart[i] != 2'b00) && !busyVec[i]) begin
                    pend[i]  <= 1'b1;
                    oper[i]  <= reqStart[i][1] ? 2'b10 : 2'b01;
                    slotS[i] <= reqS[i];
                    slotD[i] <= reqD[i];
                end
            end
            case (state)
                StIdle: begin
                    if (issue) begin
                        pend[grant] <= 1'b0;
                        owner       <= grant;
                        lastFpu     <= grant;
                        state       <= StBusy;
                    end
                end
                StBusy: begin
                    if (done) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ms_mul_div_arb.sv
// tb/tb_ms_mul_div_arb.sv - Directed table-driven bench for ms_mul_div_arb.
module tb_ms_mul_div_arb;

    logic clk = 1'b0;
    logic rstn;
    logic en;
    logic err;

    ms_mul_div_arb_if intIf();
    ms_mul_div_arb_if fpuIf();
    ms_mul_div_arb_if mdIf();

`ifdef MS_MULDIV_ARB_TIMEOUT_EN
    ms_mul_div_arb #(.CTimeout(8)) dut (
        .AClkH    (clk),
        .AResetHN (rstn),
        .AClkHEn  (en),
        .AInt     (intIf),
        .AFpu     (fpuIf),
        .AMulDiv  (mdIf),
        .AErr     (err)
    );
`else
    ms_mul_div_arb dut (
        .AClkH    (clk),
        .AResetHN (rstn),
        .AClkHEn  (en),
        .AInt     (intIf),
        .AFpu     (fpuIf),
        .AMulDiv  (mdIf),
        .AErr     (err)
    );
`endif

    always #5 clk = ~clk;

    typedef struct {
        bit          who;
        logic [1:0]  st;
        logic [31:0] s;
        logic [31:0] d;
        int          lat;
        logic [1:0]  expSt;
        logic [31:0] h;
        logic [31:0] r;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;
    int   intWrCnt = 0;

    always @(negedge clk) if (intIf.WrEn === 1'b1) intWrCnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setReq(input bit who, input logic [1:0] st, input logic [31:0] s, input logic [31:0] d);
        if (who) begin
            fpuIf.Start = st; fpuIf.DataS = s; fpuIf.DataD = d;
        end else begin
            intIf.Start = st; intIf.DataS = s; intIf.DataD = d;
        end
    endtask

    task automatic unitResp(input logic wr, input logic [31:0] h, input logic [31:0] r);
        mdIf.WrEn = wr; mdIf.DataH = h; mdIf.DataR = r;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        nextCyc();
        rstn = 1'b1;
    endtask

    task automatic runVec(input vec_t v);
        logic ownWr, othWr, ownBusy;
        setReq(v.who, v.st, v.s, v.d);
        @(negedge clk);
        chk("c0_unit_start", mdIf.Start, 2'b00);
        nextCyc();
        setReq(v.who, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        @(negedge clk);
        ownBusy = v.who ? fpuIf.Busy : intIf.Busy;
        chk("issue_start", mdIf.Start, v.expSt);
        chk("issue_dataS", mdIf.DataS, v.s);
        chk("issue_dataD", mdIf.DataD, v.d);
        chk("issue_busy", ownBusy, 1'b1);
        nextCyc();
        for (int i = 1; i < v.lat; i++) begin
            @(negedge clk);
            ownWr = v.who ? fpuIf.WrEn : intIf.WrEn;
            chk("wait_wren", ownWr, 1'b0);
            chk("wait_start", mdIf.Start, 2'b00);
            nextCyc();
        end
        unitResp(1'b1, v.h, v.r);
        @(negedge clk);
        ownWr = v.who ? fpuIf.WrEn : intIf.WrEn;
        othWr = v.who ? intIf.WrEn : fpuIf.WrEn;
        chk("done_own_wren", ownWr, 1'b1);
        chk("done_oth_wren", othWr, 1'b0);
        chk("done_dataH", v.who ? fpuIf.DataH : intIf.DataH, v.h);
        chk("done_dataR", v.who ? fpuIf.DataR : intIf.DataR, v.r);
        chk("done_err", err, 1'b0);
        nextCyc();
        unitResp(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        ownBusy = v.who ? fpuIf.Busy : intIf.Busy;
        chk("after_busy", ownBusy, 1'b0);
        chk("after_wren", v.who ? fpuIf.WrEn : intIf.WrEn, 1'b0);
        nextCyc();
    endtask

    // Int div(20,6) and Fpu mul(7,6) start together; fpuFirst selects the expected winner.
    task automatic tieOp(input bit fpuFirst, input string tag);
        logic [1:0]  st1, st2;
        logic [31:0] s1, s2;
        setReq(1'b0, 2'b10, 32'd20, 32'd6);
        setReq(1'b1, 2'b01, 32'd7, 32'd6);
        st1 = fpuFirst ? 2'b01 : 2'b10;
        st2 = fpuFirst ? 2'b10 : 2'b01;
        s1  = fpuFirst ? 32'd7 : 32'd20;
        s2  = fpuFirst ? 32'd20 : 32'd7;
        nextCyc();
        setReq(1'b0, 2'b00, 32'd0, 32'd0);
        setReq(1'b1, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        chk({tag, "_first_start"}, mdIf.Start, st1);
        chk({tag, "_first_dataS"}, mdIf.DataS, s1);
        chk({tag, "_int_busy"}, intIf.Busy, 1'b1);
        chk({tag, "_fpu_busy"}, fpuIf.Busy, 1'b1);
        nextCyc();
        unitResp(1'b1, 32'd3, 32'd2);
        @(negedge clk);
        chk({tag, "_first_wren"}, fpuFirst ? fpuIf.WrEn : intIf.WrEn, 1'b1);
        chk({tag, "_second_wren0"}, fpuFirst ? intIf.WrEn : fpuIf.WrEn, 1'b0);
        nextCyc();
        unitResp(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk({tag, "_second_start"}, mdIf.Start, st2);
        chk({tag, "_second_dataS"}, mdIf.DataS, s2);
        nextCyc();
        unitResp(1'b1, 32'd0, 32'd42);
        @(negedge clk);
        chk({tag, "_second_wren"}, fpuFirst ? intIf.WrEn : fpuIf.WrEn, 1'b1);
        chk({tag, "_first_wren0"}, fpuFirst ? fpuIf.WrEn : intIf.WrEn, 1'b0);
        nextCyc();
        unitResp(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk({tag, "_idle_busy"}, {intIf.Busy, fpuIf.Busy}, 2'b00);
        nextCyc();
    endtask

    initial begin
        int wrBase;
        vecs[0] = '{1'b0, 2'b01, 32'd3, 32'd5, 4, 2'b01, 32'd0, 32'd15};
        vecs[1] = '{1'b1, 2'b01, 32'h0001_0000, 32'h0001_0000, 2, 2'b01, 32'd1, 32'd0};
        vecs[2] = '{1'b0, 2'b10, 32'd100, 32'd7, 3, 2'b10, 32'd14, 32'd2};
        vecs[3] = '{1'b1, 2'b10, 32'hFFFF_FFFF, 32'd2, 1, 2'b10, 32'h7FFF_FFFF, 32'd1};
        vecs[4] = '{1'b0, 2'b11, 32'd9, 32'd4, 2, 2'b10, 32'd2, 32'd1};

        en = 1'b1;
        setReq(1'b0, 2'b00, 32'd0, 32'd0);
        setReq(1'b1, 2'b00, 32'd0, 32'd0);
        unitResp(1'b0, 32'd0, 32'd0);
        mdIf.Busy = 1'b0;
        rstn = 1'b0;
        nextCyc();
        nextCyc();
        rstn = 1'b1;

        @(negedge clk);
        chk("rst_unit_start", mdIf.Start, 2'b00);
        chk("rst_unit_dataS", mdIf.DataS, 32'd0);
        chk("rst_unit_dataD", mdIf.DataD, 32'd0);
        chk("rst_wren", {intIf.WrEn, fpuIf.WrEn}, 2'b00);
        chk("rst_busy", {intIf.Busy, fpuIf.Busy}, 2'b00);
        chk("rst_err", err, 1'b0);
        nextCyc();

        for (int i = 0; i < 5; i++) runVec(vecs[i]);

        // Round-robin: fresh reset favours Int; after a lone Int grant the tie goes to Fpu.
        doReset();
        tieOp(1'b0, "tie1");
        runVec(vecs[0]);
        tieOp(1'b1, "tie2");

        // Owner restarts while busy are dropped; a non-owner start at completion is captured.
        wrBase = intWrCnt;
        setReq(1'b0, 2'b01, 32'd6, 32'd7);
        nextCyc();
        setReq(1'b0, 2'b00, 32'd0, 32'd0);
        nextCyc();
        setReq(1'b0, 2'b10, 32'd1, 32'd1);
        nextCyc();
        setReq(1'b0, 2'b10, 32'd2, 32'd2);
        setReq(1'b1, 2'b01, 32'd11, 32'd12);
        unitResp(1'b1, 32'd0, 32'd42);
        @(negedge clk);
        chk("rs_int_wren", intIf.WrEn, 1'b1);
        chk("rs_int_dataR", intIf.DataR, 32'd42);
        nextCyc();
        setReq(1'b0, 2'b00, 32'd0, 32'd0);
        setReq(1'b1, 2'b00, 32'd0, 32'd0);
        unitResp(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rs_fpu_issue", mdIf.Start, 2'b01);
        chk("rs_fpu_dataS", mdIf.DataS, 32'd11);
        chk("rs_int_busy", intIf.Busy, 1'b0);
        nextCyc();
        unitResp(1'b1, 32'd0, 32'd132);
        @(negedge clk);
        chk("rs_fpu_wren", fpuIf.WrEn, 1'b1);
        nextCyc();
        unitResp(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("rs_idle_start", mdIf.Start, 2'b00);
        chk("rs_int_wr_count", intWrCnt - wrBase, 32'd1);
        nextCyc();

        // Spurious unit strobe in IDLE.
        unitResp(1'b1, 32'd5, 32'd5);
        @(negedge clk);
        chk("spur_wren", {intIf.WrEn, fpuIf.WrEn}, 2'b00);
        nextCyc();
        unitResp(1'b0, 32'd0, 32'd0);
        @(negedge clk);
        chk("spur_busy", {intIf.Busy, fpuIf.Busy}, 2'b00);
        chk("spur_start", mdIf.Start, 2'b00);
        nextCyc();
        runVec(vecs[2]);

        // Clock enable low: a start is not captured.
        en = 1'b0;
        setReq(1'b0, 2'b01, 32'd1, 32'd1);
        nextCyc();
        setReq(1'b0, 2'b00, 32'd0, 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("cen_busy", intIf.Busy, 1'b0);
        chk("cen_start", mdIf.Start, 2'b00);
        nextCyc();

        // Reset with Fpu in flight and Int pending.
        setReq(1'b1, 2'b01, 32'd2, 32'd3);
        nextCyc();
        setReq(1'b1, 2'b00, 32'd0, 32'd0);
        nextCyc();
        setReq(1'b0, 2'b01, 32'd4, 32'd4);
        nextCyc();
        setReq(1'b0, 2'b00, 32'd0, 32'd0);
        @(negedge clk);
        chk("rmb_busy_pre", {intIf.Busy, fpuIf.Busy}, 2'b11);
        doReset();
        @(negedge clk);
        chk("rmb_busy_post", {intIf.Busy, fpuIf.Busy}, 2'b00);
        chk("rmb_start", mdIf.Start, 2'b00);
        nextCyc();
        unitResp(1'b1, 32'd0, 32'd6);
        @(negedge clk);
        chk("rmb_late_wren", {intIf.WrEn, fpuIf.WrEn}, 2'b00);
        nextCyc();
        unitResp(1'b0, 32'd0, 32'd0);

`ifdef MS_MULDIV_ARB_TIMEOUT_EN
        // Unit never answers: abort on the 8th BUSY cycle.
        unitResp(1'b0, 32'd0, 32'h0000_1234);
        setReq(1'b1, 2'b01, 32'd8, 32'd9);
        nextCyc();
        setReq(1'b1, 2'b00, 32'd0, 32'd0);
        nextCyc();
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i < 8) begin
                chk("to_wait_wren", fpuIf.WrEn, 1'b0);
                chk("to_wait_err", err, 1'b0);
            end else begin
                chk("to_fpu_wren", fpuIf.WrEn, 1'b1);
                chk("to_err", err, 1'b1);
                chk("to_fpu_dataR", fpuIf.DataR, 32'hFFFF_FFFF);
                chk("to_int_dataR", intIf.DataR, 32'h0000_1234);
                chk("to_int_wren", intIf.WrEn, 1'b0);
            end
            nextCyc();
        end
        @(negedge clk);
        chk("to_idle_busy", fpuIf.Busy, 1'b0);
        chk("to_idle_err", err, 1'b0);
        nextCyc();
        unitResp(1'b1, 32'd0, 32'd1);
        @(negedge clk);
        chk("to_late_wren", {intIf.WrEn, fpuIf.WrEn}, 2'b00);
        nextCyc();
        unitResp(1'b0, 32'd0, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ms_mul_div_arb.md
# ms_mul_div_arb

Arbiter and sequencer for the single shared iterative multiplier/divider, which is used by both the integer ALU and the FPU. It captures one-cycle start pulses from each requester together with their operands. It issues one operation at a time to the MulDiv unit and routes the completion strobe back to the owning requester only. It sits between the MulDiv unit and the two requester-side MulDiv ports.

## Interface
- CTimeout, 64: BUSY cycles without unit completion before abort (used only with the timeout feature).
- AClkH  in  1  clock; all state on the rising edge.
- AResetHN  in  1  synchronous, active-low reset; takes effect at an edge regardless of AClkHEn.
- AClkHEn  in  1  clock enable; with 0, no state changes except reset.
- AIntDataS, AIntDataD  in  32  integer requester operands; valid in the start cycle only.
- AIntStart  in  2  integer start pulse: [0]=mul, [1]=div. The value 2'b11 is treated as div.
- AIntDataH, AIntDataR  out  32  result/remainder returned to the integer requester.
- AIntWrEn  out  1  one-cycle completion strobe to the integer requester.
- AIntBusy  out  1  integer request is pending or in flight.
- AFpuDataS, AFpuDataD, AFpuStart, AFpuDataH, AFpuDataR, AFpuWrEn, AFpuBusy: same as the Int* ports, for the FPU.
- AMulDivDataS, AMulDivDataD  out  32  operands to the unit; zero except in the issue cycle.
- AMulDivStart  out  2  one-cycle start to the unit.
- AMulDivDataH, AMulDivDataR  in  32  unit result.
- AMulDivWrEn  in  1  unit completion strobe.
- AErr  out  1  one-cycle timeout-abort pulse; tied to 0 without the macro.

## Operation
- Each requester has a capture slot holding {Oper[1:0], DataS, DataD, Pend}.
  - A nonzero Start sets Pend and latches the operands at the edge.
  - A Start arriving while that requester's Busy=1 is dropped. The slot is unchanged.
- Busy(x) = Pend(x) | (state==BUSY & owner==x).
- FSM states are IDLE and BUSY.
- IDLE:
  - If any Pend is set, drive the granted slot onto AMulDivDataS/D/Start for one cycle.
  - Clear that slot's Pend, record the owner, and go to BUSY.
  - If no Pend is set, drive all unit outputs to 0.
- Grant rule:
  - If only one slot is pending, grant it.
  - If both are pending, use round-robin: grant the requester not granted last.
  - The last-grant pointer resets to "Fpu", so Int wins the first tie.
- BUSY:
  - When AMulDivWrEn=1, assert the owner's WrEn in the same cycle (combinational) and return to IDLE at the edge.
  - The non-owner's WrEn stays 0.
- AIntDataH/R and AFpuDataH/R forward AMulDivDataH/R unconditionally, except the owner's DataR on a timeout cycle (see Configuration).
- AMulDivWrEn while in IDLE is ignored. No requester WrEn is raised.
- Reset values:
  - state=IDLE, both Pend=0, owner=Int, pointer=Fpu.
  - Outputs: AMulDivStart=0, AMulDivDataS/D=0, AIntWrEn=AFpuWrEn=0, Busy=0, AErr=0.
- Reset mid-operation drops the in-flight operation. Its later AMulDivWrEn arrives in IDLE and is ignored.

## Timing
- Cycle 0: requester Start. Edge: slot captured.
- Cycle 1: issue, if the unit is idle. Edge: BUSY.
- Cycle k: AMulDivWrEn arrives, owner WrEn asserts in the same cycle. Edge: IDLE.
- Cycle k+1: the other pending slot may issue. Back-to-back issue spacing is therefore 1 idle-state cycle.
- Start and completion in the same cycle:
  - A new Start from the non-owner is captured normally.
  - A new Start from the owner is dropped: its Busy is still 1 in that cycle.
- With AClkHEn=0 the FSM, slots and pointer hold.
  - Combinational outputs follow the held state.
  - AMulDivWrEn seen only while AClkHEn=0 is still routed, but the FSM does not leave BUSY.
  - Requesters must pair AMulDivWrEn with AClkHEn=1.

## Configuration
- MS_MULDIV_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entering BUSY and increments each enabled BUSY cycle.
  - When it reaches CTimeout-1 with no AMulDivWrEn, the controller does all of the following in the same cycle:
    - asserts the owner WrEn;
    - forces the owner DataR to 32'hFFFFFFFF;
    - pulses AErr;
    - goes to IDLE at the edge.
  - A late unit strobe is ignored.
- Not defined: BUSY waits indefinitely. AErr is constant 0 and the counter is absent.

## Test plan
- Int mul alone:
  - Stimulus: AIntStart=01, DataS=3, DataD=5. The unit answers DataR=15 after 4 cycles.
  - Response: AMulDivStart=01 in cycle 1, AIntWrEn=1 with AIntDataR=15, AFpuWrEn=0 throughout.
- Simultaneous requests:
  - Stimulus: Int div and Fpu mul in the same cycle.
  - Response: Int issued first. Fpu issued in the cycle after the Int completion. A second tie then grants Fpu first.
- Owner re-start while busy:
  - Stimulus: AIntStart pulsed while AIntBusy=1.
  - Response: dropped. Exactly one AIntWrEn occurs.
- Spurious strobe:
  - Stimulus: AMulDivWrEn in IDLE.
  - Response: no requester WrEn, state unchanged.
- Reset mid-BUSY:
  - Stimulus: AResetHN=0 for one edge, with Fpu in flight and Int pending.
  - Response: Busy=0 for both. The following AMulDivWrEn produces no WrEn.
- Timeout, with the macro defined and CTimeout=8:
  - Stimulus: the unit never answers.
  - Response: owner WrEn and AErr on the 8th BUSY cycle, owner DataR=FFFFFFFF, IDLE next cycle.
